// File: rtl/proc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_pkg : opcodes, sequencer state encoding, instruction field positions
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_t;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_decode : combinational split of the instruction register into
//                fields and class flags
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_decode
  import proc_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  op,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic        legal,
  output logic        is_imm,
  output logic        is_branch,
  output logic        is_halt
);

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign rt  = ir[RT_MSB:RT_LSB];
  assign imm = sext4(ir[RT_MSB:RT_LSB]);

  always_comb begin
    legal     = 1'b1;
    is_imm    = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    case (op)
      OP_ADD, OP_SUB:   ;
      OP_ADDI, OP_SUBI: is_imm    = 1'b1;
      OP_BEQ:           is_branch = 1'b1;
      OP_HALT:          is_halt   = 1'b1;
      default:          legal     = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_sequencer : FETCH/DECODE/EXEC/WB/HALT instruction sequencer
//                   Optional macro SEQ_STEP_EN gates each fetch on a step pulse.
// Revision        : 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_sequencer
  import proc_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  output logic [3:0]  rf_wa,
  output logic        rf_we,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_imm,
  input  logic        alu_zero,
  input  logic        step,
  output logic        halted,
  output logic [15:0] retired
);

  seq_state_t  state;
  logic [15:0] pc;
  logic [15:0] ir;

  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs;
  logic [3:0]  dec_rt;
  logic [15:0] dec_imm;
  logic        dec_legal;
  logic        dec_is_imm;
  logic        dec_is_branch;
  logic        dec_is_halt;

  logic        can_issue;
  logic        req_after_wb;

  instr_decode u_decode (
    .ir        (ir),
    .op        (dec_op),
    .rd        (dec_rd),
    .rs        (dec_rs),
    .rt        (dec_rt),
    .imm       (dec_imm),
    .legal     (dec_legal),
    .is_imm    (dec_is_imm),
    .is_branch (dec_is_branch),
    .is_halt   (dec_is_halt)
  );

  assign imem_addr = pc;
  assign rf_ra     = dec_rs;
  // beq compares rs against rd, so rd is steered onto the second read port
  assign rf_rb     = dec_is_branch ? dec_rd : dec_rt;
  assign rf_wa     = dec_rd;
  assign alu_imm   = dec_is_imm ? dec_imm : 16'h0000;

`ifdef SEQ_STEP_EN
  logic step_pending;

  // A pulse seen anywhere is remembered once; it is spent when FETCH raises imem_req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pending <= 1'b0;
    end else if (state == ST_FETCH && !imem_req && step_pending) begin
      step_pending <= step;
    end else if (step) begin
      step_pending <= 1'b1;
    end
  end

  assign can_issue    = step_pending;
  assign req_after_wb = 1'b0;
`else
  logic unused_step;
  assign unused_step  = step;
  assign can_issue    = 1'b1;
  assign req_after_wb = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      pc         <= PC_RESET;
      ir         <= 16'h0000;
      retired    <= 16'h0000;
      rf_we      <= 1'b0;
      imem_req   <= 1'b0;
      alu_opcode <= OP_NOP;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_req) begin
            if (imem_valid) begin
              ir       <= imem_data;
              imem_req <= 1'b0;
              state    <= ST_DECODE;
            end
          end else if (can_issue) begin
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_legal && !dec_is_halt) begin
            alu_opcode <= dec_is_branch ? OP_SUB : dec_op;
            state      <= ST_EXEC;
          end else begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end
        end
        ST_EXEC: begin
          alu_opcode <= OP_NOP;
          rf_we      <= !dec_is_branch;
          state      <= ST_WB;
        end
        ST_WB: begin
          rf_we    <= 1'b0;
          pc       <= (dec_is_branch && alu_zero) ? (pc + 16'd1 + dec_imm) : (pc + 16'd1);
          retired  <= retired + 16'd1;
          imem_req <= req_after_wb;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          halted     <= 1'b1;
          imem_req   <= 1'b0;
          rf_we      <= 1'b0;
          alu_opcode <= OP_NOP;
        end
        default: begin
          halted <= 1'b1;
          state  <= ST_HALT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_sequencer : directed self-checking bench for instr_sequencer
// Revision           : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data  = 16'h0000;
  logic [3:0]  rf_ra;
  logic [3:0]  rf_rb;
  logic [3:0]  rf_wa;
  logic        rf_we;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_imm;
  logic        alu_zero = 1'b0;
  logic        step     = 1'b0;
  logic        halted;
  logic [15:0] retired;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cur_pc   = 16'h0000;
  logic [15:0] exp_ret  = 16'h0000;

`ifdef SEQ_STEP_EN
  localparam logic FREE_RUN = 1'b0;
`else
  localparam logic FREE_RUN = 1'b1;
`endif

  instr_sequencer #(.PC_RESET(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .rf_ra      (rf_ra),
    .rf_rb      (rf_rb),
    .rf_wa      (rf_wa),
    .rf_we      (rf_we),
    .alu_opcode (alu_opcode),
    .alu_imm    (alu_imm),
    .alu_zero   (alu_zero),
    .step       (step),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Asynchronous reset checked mid-cycle, then released; ends one negedge after release
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req",     imem_req,   1'b0);
    check("rst_we",      rf_we,      1'b0);
    check("rst_halted",  halted,     1'b0);
    check("rst_retired", retired,    16'h0000);
    check("rst_aluop",   alu_opcode, 4'h0);
    check("rst_addr",    imem_addr,  16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("req_after_rst", imem_req, FREE_RUN);
    cur_pc  = 16'h0000;
    exp_ret = 16'h0000;
  endtask

  // Fetch one instruction (after 'delay' idle request cycles) and check each stage
  task automatic run(input logic [15:0] instr, input int delay, input logic zero,
                     input logic [3:0] e_op, input logic [3:0] e_rb, input logic [15:0] e_imm,
                     input logic e_we, input logic [15:0] e_pc);
    for (int i = 0; i < delay; i++) begin
      check("req_wait",  imem_req,  1'b1);
      check("addr_wait", imem_addr, cur_pc);
      check("we_wait",   rf_we,     1'b0);
      @(negedge clk);
    end
    check("req_fetch",  imem_req,  1'b1);
    check("addr_fetch", imem_addr, cur_pc);
    imem_valid = 1'b1;
    imem_data  = instr;
    alu_zero   = zero;
    @(negedge clk);
    imem_valid = 1'b0;
    check("req_decode", imem_req,   1'b0);
    check("op_decode",  alu_opcode, 4'h0);
    @(negedge clk);
    check("alu_op",  alu_opcode, e_op);
    check("rf_ra",   rf_ra,      instr[7:4]);
    check("rf_rb",   rf_rb,      e_rb);
    check("alu_imm", alu_imm,    e_imm);
    check("we_exec", rf_we,      1'b0);
    @(negedge clk);
    check("rf_we", rf_we, e_we);
    if (e_we) check("rf_wa", rf_wa, instr[11:8]);
    check("op_wb", alu_opcode, 4'h0);
    @(negedge clk);
    exp_ret = exp_ret + 16'd1;
    check("next_pc",   imem_addr, e_pc);
    check("retired",   retired,   exp_ret);
    check("req_again", imem_req,  1'b1);
    cur_pc = e_pc;
  endtask

  // Illegal or halt opcode: sequencer must park with no requests, ignoring imem_valid
  task automatic halt_test(input logic [15:0] instr);
    check("req_halt_fetch", imem_req, 1'b1);
    imem_valid = 1'b1;
    imem_data  = instr;
    @(negedge clk);
    check("halted_decode", halted, 1'b0);
    for (int i = 0; i < 22; i++) begin
      imem_valid = i[0];
      imem_data  = 16'h2123;
      @(negedge clk);
      check("halted",       halted,    1'b1);
      check("req_halted",   imem_req,  1'b0);
      check("we_halted",    rf_we,     1'b0);
      check("ret_halted",   retired,   exp_ret);
      check("addr_halted",  imem_addr, cur_pc);
    end
    imem_valid = 1'b0;
    do_reset();
    check("halted_cleared", halted, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
`ifndef SEQ_STEP_EN
    run(16'h2123, 0, 1'b0, 4'h2, 4'h3, 16'h0000, 1'b1, 16'h0001);  // add r1,r2,r3
    run(16'h3456, 3, 1'b0, 4'h3, 4'h6, 16'h0000, 1'b1, 16'h0002);  // sub, valid late
    run(16'hA71D, 0, 1'b0, 4'hA, 4'hD, 16'hFFFD, 1'b1, 16'h0003);  // addi r7,r1,-3
    run(16'hB895, 0, 1'b0, 4'hB, 4'h5, 16'h0005, 1'b1, 16'h0004);  // subi r8,r9,5
    run(16'h623E, 0, 1'b0, 4'h3, 4'h2, 16'h0000, 1'b0, 16'h0005);  // beq not taken
    run(16'h612D, 0, 1'b1, 4'h3, 4'h1, 16'h0000, 1'b0, 16'h0003);  // beq taken, -3

    do_reset();
    run(16'h610E, 0, 1'b1, 4'h3, 4'h1, 16'h0000, 1'b0, 16'hFFFF);  // beq -2 from 0
    run(16'h2123, 0, 1'b0, 4'h2, 4'h3, 16'h0000, 1'b1, 16'h0000);  // PC wraps
    run(16'h610E, 0, 1'b0, 4'h3, 4'h1, 16'h0000, 1'b0, 16'h0001);  // beq not taken

    halt_test(16'h5000);
    run(16'h2123, 0, 1'b0, 4'h2, 4'h3, 16'h0000, 1'b1, 16'h0001);
    halt_test(16'hF000);

    // Reset while in WB
    run(16'h2123, 0, 1'b0, 4'h2, 4'h3, 16'h0000, 1'b1, 16'h0001);
    imem_valid = 1'b1;
    imem_data  = 16'h2456;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("we_before_rst", rf_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("we_rst_wb",      rf_we,     1'b0);
    check("addr_rst_wb",    imem_addr, 16'h0000);
    check("retired_rst_wb", retired,   16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("req_after_wb_rst",  imem_req,  1'b1);
    check("addr_after_wb_rst", imem_addr, 16'h0000);
    check("ret_after_wb_rst",  retired,   16'h0000);
`else
    imem_valid = 1'b1;
    imem_data  = 16'h2123;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("req_no_step", imem_req, 1'b0);
    end
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (int t = 0; t < 12 && retired != 16'(k); t++) @(negedge clk);
      check("step_retired", retired, 16'(k));
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        check("req_idle_step", imem_req, 1'b0);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("req_after_steps", imem_req, 1'b0);
    end
    check("steps_total", retired,   16'd3);
    check("steps_pc",    imem_addr, 16'd3);
    imem_valid = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_RESET, default 16'h0000, is the program counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction fetch request, held until accepted.
REQ-005 imem_addr  output  16  fetch address, equal to the PC.
REQ-006 imem_valid  input  1  fetch data valid; sampled only in FETCH.
REQ-007 imem_data  input  16  instruction word: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
REQ-008 rf_ra, rf_rb  output  4 each  register-file read addresses (rs, and rt or rd).
REQ-009 rf_wa  output  4  write address (rd); rf_we  output  1  single-cycle write strobe.
REQ-010 alu_opcode  output  4  opcode presented to the ALU; alu_imm  output  16  sign-extended imm4.
REQ-011 alu_zero  input  1  ALU zero flag, sampled in WB only.
REQ-012 step  input  1  single-step pulse (see Configuration).
REQ-013 halted  output  1  high while in HALT; retired  output  16  retired-instruction count.

Function
REQ-014 FSM states: FETCH, DECODE, EXEC, WB, HALT; one state per cycle except FETCH and HALT.
REQ-015 FETCH: imem_req=1 and imem_addr=PC; on imem_valid=1, latch imem_data into IR and go to DECODE; otherwise stay.
REQ-016 DECODE: legal ops 0010 add, 0011 sub, 1010 addi, 1011 subi, 0110 beq, 1111 halt; go to EXEC, or to HALT for 1111 or any other op.
REQ-017 EXEC: alu_opcode = IR op for ALU ops; for beq, alu_opcode=0011 with rf_ra=rs and rf_rb=rd; for register ops, rf_rb=rt; for immediate ops, alu_imm = sext(imm4); next state WB.
REQ-018 Outside EXEC, alu_opcode=4'b0000 (ALU no-op).
REQ-019 WB for add/sub/addi/subi: rf_we=1 for exactly this cycle with rf_wa=rd; PC <= PC+1.
REQ-020 WB for beq: rf_we=0; PC <= PC+1+sext(imm4) if alu_zero=1, else PC+1.
REQ-021 All PC arithmetic is 16-bit modulo 2^16: 16'hFFFF+1 = 16'h0000, and negative offsets wrap.
REQ-022 retired increments by 1 on every WB cycle and wraps from 16'hFFFF to 0; halt and illegal instructions do not count.
REQ-023 HALT: halted=1, imem_req=0, rf_we=0; the state is left only by reset.
REQ-024 imem_valid outside FETCH is ignored, and rf_we is never asserted outside WB.
REQ-025 Latency: 4 cycles per ALU or branch instruction when imem_valid is returned in the first FETCH cycle.

Reset
REQ-026 rst=1 forces, immediately and regardless of clk: state=FETCH, PC=PC_RESET, IR=0, retired=0, rf_we=0, imem_req=0 while rst is held, alu_opcode=0, halted=0.
REQ-027 Reset asserted mid-instruction, including during WB, drops rf_we in the same cycle and commits no PC or count update.
REQ-028 The first FETCH request occurs in the first clock edge after rst deasserts.

Configuration
REQ-029 Macro SEQ_STEP_EN defined: FETCH asserts imem_req only after a step=1 pulse has been captured; one pulse permits exactly one instruction, and pulses arriving in other states are held as a single pending step.
REQ-030 Macro SEQ_STEP_EN undefined: the step port is present but ignored, and the sequencer free-runs.

Structure
REQ-031 Shared package proc_pkg holds the opcode localparams, the state encoding, and the instruction field bit positions; the ALU and this block both use it.
REQ-032 One combinational sub-module, instr_decode, maps IR to legality, is_imm, is_branch, is_halt, and the register/immediate fields.

Verification
REQ-033 Reset then add r1,r2,r3 (op 2, imem_valid in the first cycle) -> rf_we=1 with rf_wa=1 in cycle 4, imem_addr=1 in cycle 5, retired=1.
REQ-034 imem_valid delayed 3 cycles -> imem_req held high for 4 cycles, with no rf_we and no PC change until acceptance.
REQ-035 beq with imm4=4'hE and alu_zero=1 at PC=16'h0000 -> next PC=16'hFFFF; with alu_zero=0 -> next PC=16'h0001.
REQ-036 Op 4'b0101 or 4'b1111 -> halted=1 and imem_req=0 for 20 or more cycles, retired unchanged; rst pulse -> FETCH at PC_RESET.
REQ-037 rst asserted during WB -> rf_we=0 within the same cycle, PC=PC_RESET, and retired=0.
REQ-038 SEQ_STEP_EN defined with 3 step pulses -> exactly 3 instructions retire, and no imem_req without a pending step.
